issue_rr_pipe: RTL and testbench

Parametrised, elastic Issue→RegRead pipeline for the issue path. It carries one payload per lane through DEPTH register stages with per-lane valid/ready backpressure and bubble collapsing. In-flight packets are killed selectively on branch mispredict, and surviving packets have their resolved branch-mask bits cleared. It sits between the issue-queue select/payload read and the physical register file read, and replaces the fixed single-stage, non-stallable issue/RR register.

---
 rtl/issue_rr_pkg.sv | 39 +++
 rtl/issue_rr_pipe_if.sv | 30 +++
 rtl/rr_lane_pipe.sv | 107 ++++++++++
 rtl/issue_rr_pipe.sv | 59 +++++
 tb/tb_issue_rr_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_rr_pkg.sv
// Shared types and helpers for the Issue->RegRead pipeline.
// Per-lane widths follow the module parameters; the defaults below match the issue path.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 4
`endif
`ifndef PAYLOAD_PKT_SIZE
`define PAYLOAD_PKT_SIZE 32
`endif

package issue_rr_pkg;

  localparam int unsigned IssueWidth     = `ISSUE_WIDTH;
  localparam int unsigned PayloadPktSize = `PAYLOAD_PKT_SIZE;
  localparam int unsigned BmaskWDflt     = 8;

  // Helpers take the widest supported mask so any BMASK_W up to 64 can share them.
  localparam int unsigned MaxBmaskW = 64;
  localparam int unsigned MaxTagW   = 6;

  typedef struct packed {
    logic                      v;
    logic [BmaskWDflt-1:0]     brMask;
    logic [PayloadPktSize-1:0] data;
  } rr_stage_t;

  function automatic logic bmask_hit(input logic [MaxBmaskW-1:0] mask,
                                     input logic [MaxTagW-1:0]   tag);
    return mask[tag];
  endfunction

  function automatic logic [MaxBmaskW-1:0] bmask_clear(input logic [MaxBmaskW-1:0] mask,
                                                       input logic [MaxTagW-1:0]   tag);
    logic [MaxBmaskW-1:0] m;
    m      = mask;
    m[tag] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/issue_rr_pipe_if.sv
// Per-lane valid/ready handshake bundle between issue select, the pipe and regfile read.
interface issue_rr_pipe_if
  import issue_rr_pkg::*;
#(
  parameter int unsigned NUM_LANES = IssueWidth,
  parameter int unsigned BMASK_W   = BmaskWDflt,
  parameter int unsigned PKT_W     = PayloadPktSize
);

  logic [NUM_LANES-1:0]              inValid_i;
  logic [NUM_LANES-1:0][BMASK_W-1:0] inBrMask_i;
  logic [NUM_LANES-1:0][PKT_W-1:0]   inData_i;
  logic [NUM_LANES-1:0]              inReady_o;
  logic [NUM_LANES-1:0]              outValid_o;
  logic [NUM_LANES-1:0][BMASK_W-1:0] outBrMask_o;
  logic [NUM_LANES-1:0][PKT_W-1:0]   outData_o;
  logic [NUM_LANES-1:0]              outReady_i;

  // master: the surrounding issue/regfile logic; slave: the pipe itself
  modport master (
    output inValid_i, inBrMask_i, inData_i, outReady_i,
    input  inReady_o, outValid_o, outBrMask_o, outData_o
  );

  modport slave (
    input  inValid_i, inBrMask_i, inData_i, outReady_i,
    output inReady_o, outValid_o, outBrMask_o, outData_o
  );

endinterface

// File: rtl/rr_lane_pipe.sv
// One lane of the elastic Issue->RegRead pipe: DEPTH stages with bubble collapsing,
// selective squash on mispredict and branch-mask clearing on correct resolve.
module rr_lane_pipe
  import issue_rr_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PKT_W   = PayloadPktSize,
  parameter int unsigned BMASK_W = BmaskWDflt
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       active_i,
  input  logic                       br_resolve_i,
  input  logic                       br_squash_i,
  input  logic [$clog2(BMASK_W)-1:0] br_tag_i,
  input  logic                       in_valid_i,
  input  logic [BMASK_W-1:0]         in_br_mask_i,
  input  logic [PKT_W-1:0]           in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [BMASK_W-1:0]         out_br_mask_o,
  output logic [PKT_W-1:0]           out_data_o,
  input  logic                       out_ready_i,
  output logic                       busy_o
);

  localparam int Last = int'(DEPTH) - 1;

  logic [DEPTH-1:0]              v_q, v_d;
  logic [DEPTH-1:0][BMASK_W-1:0] mask_q, mask_d;
  logic [DEPTH-1:0][PKT_W-1:0]   data_q, data_d;

  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] adv;
  logic             squash;
  logic             resolve_ok;
  logic             in_hit;
  logic             space;
  logic             capture;

  always_comb begin
    squash     = br_resolve_i & br_squash_i;
    resolve_ok = br_resolve_i & ~br_squash_i;
    in_hit     = squash & bmask_hit(MaxBmaskW'(in_br_mask_i), MaxTagW'(br_tag_i));
    kill       = '0;
    adv        = '0;
    for (int k = 0; k <= Last; k++) begin
      kill[k] = squash & bmask_hit(MaxBmaskW'(mask_q[k]), MaxTagW'(br_tag_i));
    end
    // Walk from the output back: a stage moves if any slot ahead of it is free or draining.
    // Kill is deliberately left out so the ready path never depends on the squash.
    space = out_ready_i;
    for (int k = Last; k >= 0; k--) begin
      adv[k] = active_i & v_q[k] & space;
      space  = space | ~v_q[k];
    end
    in_ready_o = active_i & space;
    capture    = in_valid_i & in_ready_o & ~in_hit;
  end

  always_comb begin
    v_d    = v_q & ~kill & ~adv;
    mask_d = mask_q;
    data_d = data_q;
    if (capture) begin
      v_d[0]    = 1'b1;
      mask_d[0] = in_br_mask_i;
      data_d[0] = in_data_i;
    end
    for (int k = 1; k <= Last; k++) begin
      if (adv[k-1]) begin
        v_d[k]    = ~kill[k-1];
        mask_d[k] = mask_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end
    if (resolve_ok) begin
      for (int k = 0; k <= Last; k++) begin
        mask_d[k] = BMASK_W'(bmask_clear(MaxBmaskW'(mask_d[k]), MaxTagW'(br_tag_i)));
      end
    end
    if (flush_i) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= '0;
      mask_q <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      mask_q <= mask_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    out_valid_o   = active_i & v_q[Last] & ~kill[Last];
    out_br_mask_o = mask_q[Last];
    out_data_o    = data_q[Last];
    busy_o        = |v_q;
  end

endmodule

// File: rtl/issue_rr_pipe.sv
// Elastic Issue->RegRead pipeline: NUM_LANES independent lanes of DEPTH stages each.
// The top only fans out branch, flush and lane-enable controls to the lanes.
module issue_rr_pipe
  import issue_rr_pkg::*;
#(
  parameter int unsigned NUM_LANES = IssueWidth,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned PKT_W     = PayloadPktSize,
  parameter int unsigned BMASK_W   = BmaskWDflt
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic [NUM_LANES-1:0]       laneActive_i,
  input  logic                       brResolve_i,
  input  logic                       brSquash_i,
  input  logic [$clog2(BMASK_W)-1:0] brTag_i,
  issue_rr_pipe_if.slave             bus,
  output logic [NUM_LANES-1:0]       laneBusy_o
);

  logic [NUM_LANES-1:0]              in_ready;
  logic [NUM_LANES-1:0]              out_valid;
  logic [NUM_LANES-1:0][BMASK_W-1:0] out_mask;
  logic [NUM_LANES-1:0][PKT_W-1:0]   out_data;
  logic [NUM_LANES-1:0]              busy;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rr_lane_pipe #(
      .DEPTH   (DEPTH),
      .PKT_W   (PKT_W),
      .BMASK_W (BMASK_W)
    ) u_lane (
      .clk           (clk),
      .reset         (reset),
      .flush_i       (flush_i),
      .active_i      (laneActive_i[g]),
      .br_resolve_i  (brResolve_i),
      .br_squash_i   (brSquash_i),
      .br_tag_i      (brTag_i),
      .in_valid_i    (bus.inValid_i[g]),
      .in_br_mask_i  (bus.inBrMask_i[g]),
      .in_data_i     (bus.inData_i[g]),
      .in_ready_o    (in_ready[g]),
      .out_valid_o   (out_valid[g]),
      .out_br_mask_o (out_mask[g]),
      .out_data_o    (out_data[g]),
      .out_ready_i   (bus.outReady_i[g]),
      .busy_o        (busy[g])
    );
  end

  assign bus.inReady_o   = in_ready;
  assign bus.outValid_o  = out_valid;
  assign bus.outBrMask_o = out_mask;
  assign bus.outData_o   = out_data;
  assign laneBusy_o      = busy;

endmodule

// File: tb/tb_issue_rr_pipe.sv
// Bench for issue_rr_pipe: DEPTH=2 and DEPTH=3 instances share stimulus and are checked
// against a slot-occupancy reference model plus directed vectors.
module tb_issue_rr_pipe;
  localparam int NL = 4;
  localparam int BW = 8;
  localparam int PW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic [NL-1:0]        lane_active;
  logic                 br_resolve;
  logic                 br_squash;
  logic [2:0]           br_tag;
  logic [NL-1:0]        in_valid;
  logic [NL-1:0]        out_ready;
  logic [NL-1:0][BW-1:0] in_mask;
  logic [NL-1:0][PW-1:0] in_data;
  logic [NL-1:0]        busy2, busy3;

  int n_vec;
  int n_miss;

  // reference state: [dut][lane][slot], dut 0 = depth 2, dut 1 = depth 3
  bit           mv [2][NL][4];
  logic [BW-1:0] mm [2][NL][4];
  logic [PW-1:0] md [2][NL][4];

  issue_rr_pipe_if #(.NUM_LANES(NL), .BMASK_W(BW), .PKT_W(PW)) if2 ();
  issue_rr_pipe_if #(.NUM_LANES(NL), .BMASK_W(BW), .PKT_W(PW)) if3 ();

  assign if2.inValid_i  = in_valid;
  assign if2.inBrMask_i = in_mask;
  assign if2.inData_i   = in_data;
  assign if2.outReady_i = out_ready;
  assign if3.inValid_i  = in_valid;
  assign if3.inBrMask_i = in_mask;
  assign if3.inData_i   = in_data;
  assign if3.outReady_i = out_ready;

  issue_rr_pipe #(.NUM_LANES(NL), .DEPTH(2), .PKT_W(PW), .BMASK_W(BW)) u_dut2 (
    .clk(clk), .reset(reset), .flush_i(flush), .laneActive_i(lane_active),
    .brResolve_i(br_resolve), .brSquash_i(br_squash), .brTag_i(br_tag),
    .bus(if2.slave), .laneBusy_o(busy2)
  );

  issue_rr_pipe #(.NUM_LANES(NL), .DEPTH(3), .PKT_W(PW), .BMASK_W(BW)) u_dut3 (
    .clk(clk), .reset(reset), .flush_i(flush), .laneActive_i(lane_active),
    .brResolve_i(br_resolve), .brSquash_i(br_squash), .brTag_i(br_tag),
    .bus(if3.slave), .laneBusy_o(busy3)
  );

  always #5 clk = ~clk;

  function automatic int dep_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packets advance one slot whenever any slot ahead of them is free; the oldest leaves on ready.
  task automatic model_tick();
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < NL; l++) begin
        int            depth, last, occ, np;
        bit            departs, can_take, sq, ok, hole;
        bit            nv [4];
        logic [BW-1:0] nm [4];
        logic [PW-1:0] nd [4];
        depth = dep_of(d);
        last  = depth - 1;
        sq    = br_resolve && br_squash;
        ok    = br_resolve && !br_squash;
        if (reset) begin
          for (int k = 0; k < 4; k++) begin
            mv[d][l][k] = 0; mm[d][l][k] = '0; md[d][l][k] = '0;
          end
        end else if (flush) begin
          for (int k = 0; k < 4; k++) mv[d][l][k] = 0;
        end else if (!lane_active[l]) begin
          for (int k = 0; k < depth; k++) begin
            if (sq && mm[d][l][k][br_tag]) mv[d][l][k] = 0;
            if (ok) mm[d][l][k][br_tag] = 1'b0;
          end
        end else begin
          occ = 0;
          for (int k = 0; k < depth; k++) occ += int'(mv[d][l][k]);
          departs  = mv[d][l][last] && out_ready[l];
          can_take = (occ < depth) || departs;
          for (int k = 0; k < 4; k++) begin
            nv[k] = 0; nm[k] = '0; nd[k] = '0;
          end
          for (int k = 0; k < depth; k++) begin
            if (mv[d][l][k] && !(k == last && departs)) begin
              hole = 0;
              for (int j = k + 1; j < depth; j++)
                if (!mv[d][l][j] || (j == last && departs)) hole = 1;
              np     = k + int'(hole);
              nv[np] = 1; nm[np] = mm[d][l][k]; nd[np] = md[d][l][k];
            end
          end
          if (in_valid[l] && can_take && !(sq && in_mask[l][br_tag])) begin
            nv[0] = 1; nm[0] = in_mask[l]; nd[0] = in_data[l];
          end
          for (int k = 0; k < depth; k++) begin
            if (sq && nm[k][br_tag]) nv[k] = 0;
            if (ok) nm[k][br_tag] = 1'b0;
            mv[d][l][k] = nv[k]; mm[d][l][k] = nm[k]; md[d][l][k] = nd[k];
          end
        end
      end
    end
  endtask

  // Settle the current inputs and compare both DUTs with the model.
  task automatic apply();
    #1;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        logic [NL-1:0]         e_v, e_r, e_b, a_v, a_r, a_b;
        logic [NL-1:0][BW-1:0] a_m;
        logic [NL-1:0][PW-1:0] a_d;
        int                    depth, last, occ;
        if (d == 0) begin
          a_v = if2.outValid_o; a_r = if2.inReady_o; a_b = busy2;
          a_m = if2.outBrMask_o; a_d = if2.outData_o;
        end else begin
          a_v = if3.outValid_o; a_r = if3.inReady_o; a_b = busy3;
          a_m = if3.outBrMask_o; a_d = if3.outData_o;
        end
        depth = dep_of(d);
        last  = depth - 1;
        for (int l = 0; l < NL; l++) begin
          occ = 0;
          for (int k = 0; k < depth; k++) occ += int'(mv[d][l][k]);
          e_v[l] = lane_active[l] && mv[d][l][last] &&
                   !(br_resolve && br_squash && mm[d][l][last][br_tag]);
          e_r[l] = lane_active[l] && ((occ < depth) || out_ready[l]);
          e_b[l] = (occ != 0);
        end
        check($sformatf("D%0d in_ready", depth), 32'(a_r), 32'(e_r));
        check($sformatf("D%0d out_valid", depth), 32'(a_v), 32'(e_v));
        check($sformatf("D%0d lane_busy", depth), 32'(a_b), 32'(e_b));
        for (int l = 0; l < NL; l++) begin
          if (e_v[l]) begin
            check($sformatf("D%0d lane%0d out_data", depth, l), 32'(a_d[l]),
                  32'(md[d][l][last]));
            check($sformatf("D%0d lane%0d out_mask", depth, l), 32'(a_m[l]),
                  32'(mm[d][l][last]));
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  typedef struct {
    logic          in_v;
    logic [PW-1:0] in_d;
    logic          e_v2;
    logic [PW-1:0] e_d2;
    logic          e_v3;
    logic [PW-1:0] e_d3;
  } vec_t;

  initial begin
    vec_t          tbl [11];
    logic [PW-1:0] got2 [$];
    logic [PW-1:0] got3 [$];
    logic [BW-1:0] gm2 [$];
    logic [BW-1:0] gm3 [$];

    n_vec = 0;
    n_miss = 0;
    reset = 1'b1; flush = 1'b0; lane_active = '1;
    br_resolve = 1'b0; br_squash = 1'b0; br_tag = '0;
    in_valid = '0; out_ready = '1; in_mask = '0; in_data = '0;

    // Lane-0 stream 0x1..0x8: depth 2 emits t-2 cycles later, depth 3 t-3.
    for (int t = 0; t < 11; t++) begin
      tbl[t].in_v = (t < 8);
      tbl[t].in_d = PW'(t + 1);
      tbl[t].e_v2 = (t >= 2) && (t < 10);
      tbl[t].e_d2 = PW'(t - 1);
      tbl[t].e_v3 = (t >= 3) && (t < 11);
      tbl[t].e_d3 = PW'(t - 2);
    end

    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    apply();
    check("rst out_valid D2", 32'(if2.outValid_o), 32'h0);
    check("rst out_valid D3", 32'(if3.outValid_o), 32'h0);
    check("rst busy D2", 32'(busy2), 32'h0);
    check("rst busy D3", 32'(busy3), 32'h0);
    check("rst in_ready D2", 32'(if2.inReady_o), 32'hf);
    check("rst in_ready D3", 32'(if3.inReady_o), 32'hf);
    check("rst out_mask D2", 32'(if2.outBrMask_o), 32'h0);
    check("rst out_data D3", 32'(if3.outData_o[1:0]), 32'h0);
    tick();

    for (int t = 0; t < 11; t++) begin
      in_valid   = {3'b000, tbl[t].in_v};
      in_data[0] = tbl[t].in_d;
      in_mask[0] = '0;
      apply();
      check("stream v D2", 32'(if2.outValid_o[0]), 32'(tbl[t].e_v2));
      check("stream v D3", 32'(if3.outValid_o[0]), 32'(tbl[t].e_v3));
      if (tbl[t].e_v2) check("stream d D2", 32'(if2.outData_o[0]), 32'(tbl[t].e_d2));
      if (tbl[t].e_v3) check("stream d D3", 32'(if3.outData_o[0]), 32'(tbl[t].e_d3));
      tick();
    end

    // Full stall: lane fills to DEPTH, then ready propagates back in the release cycle.
    out_ready = '0;
    in_valid  = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      in_data[0] = PW'(16'h20 + c);
      apply();
      check("stall in_ready D2", 32'(if2.inReady_o[0]), 32'(c < 2));
      check("stall in_ready D3", 32'(if3.inReady_o[0]), 32'(c < 3));
      tick();
    end
    out_ready = '1;
    for (int c = 0; c < 6; c++) begin
      in_data[0] = PW'(16'h40 + c);
      apply();
      if (c == 0) begin
        check("release in_ready D3", 32'(if3.inReady_o[0]), 32'h1);
        check("release head D3", 32'(if3.outData_o[0]), 32'h20);
        check("release head D2", 32'(if2.outData_o[0]), 32'h20);
      end
      tick();
    end
    in_valid = '0;
    for (int c = 0; c < 5; c++) begin
      apply();
      tick();
    end

    // Squash tag 0 with masks 01, 02, 01 in flight; only the 02 packet survives.
    for (int c = 0; c < 8; c++) begin
      in_valid   = (c < 3) ? 4'b0001 : 4'b0000;
      in_mask[0] = (c == 1) ? 8'h02 : 8'h01;
      in_data[0] = PW'(16'ha + c);
      br_resolve = (c == 2);
      br_squash  = (c == 2);
      br_tag     = 3'd0;
      apply();
      if (c == 2) check("squash cycle out_valid D2", 32'(if2.outValid_o[0]), 32'h0);
      if (if2.outValid_o[0]) got2.push_back(if2.outData_o[0]);
      if (if3.outValid_o[0]) got3.push_back(if3.outData_o[0]);
      tick();
    end
    br_resolve = 1'b0; br_squash = 1'b0;
    check("squash count D2", 32'(got2.size()), 32'd1);
    check("squash count D3", 32'(got3.size()), 32'd1);
    if (got2.size() > 0) check("squash survivor D2", 32'(got2[0]), 32'hb);
    if (got3.size() > 0) check("squash survivor D3", 32'(got3[0]), 32'hb);

    // Correct resolve of tag 2 on an in-flight 0x05 mask.
    got2.delete(); got3.delete();
    for (int c = 0; c < 6; c++) begin
      in_valid   = (c == 0) ? 4'b0001 : 4'b0000;
      in_mask[0] = 8'h05;
      in_data[0] = 16'h00d0;
      br_resolve = (c == 1);
      br_squash  = 1'b0;
      br_tag     = 3'd2;
      apply();
      if (if2.outValid_o[0]) begin got2.push_back(if2.outData_o[0]); gm2.push_back(if2.outBrMask_o[0]); end
      if (if3.outValid_o[0]) begin got3.push_back(if3.outData_o[0]); gm3.push_back(if3.outBrMask_o[0]); end
      tick();
    end
    br_resolve = 1'b0;
    check("resolve count D2", 32'(got2.size()), 32'd1);
    check("resolve count D3", 32'(got3.size()), 32'd1);
    if (gm2.size() > 0) check("resolve mask D2", 32'(gm2[0]), 32'h01);
    if (gm3.size() > 0) check("resolve mask D3", 32'(gm3[0]), 32'h01);

    // Flush with every lane full; the packet offered in the flush cycle is dropped.
    out_ready = '0;
    in_valid  = '1;
    in_mask   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < NL; l++) in_data[l] = PW'(16'h300 + 16 * l + c);
      apply();
      tick();
    end
    flush = 1'b1;
    for (int l = 0; l < NL; l++) in_data[l] = 16'h0077;
    apply();
    check("full busy D3", 32'(busy3), 32'hf);
    tick();
    flush = 1'b0; in_valid = '0; out_ready = '1;
    for (int c = 0; c < 5; c++) begin
      apply();
      check("post flush out_valid D2", 32'(if2.outValid_o), 32'h0);
      check("post flush out_valid D3", 32'(if3.outValid_o), 32'h0);
      check("post flush busy D2", 32'(busy2), 32'h0);
      check("post flush busy D3", 32'(busy3), 32'h0);
      tick();
    end

    // Lane 2 disabled while the others stream with random backpressure.
    lane_active = 4'b1011;
    in_valid    = '1;
    for (int c = 0; c < 12; c++) begin
      out_ready = 4'($urandom);
      for (int l = 0; l < NL; l++) in_data[l] = PW'($urandom);
      apply();
      check("inactive in_ready D2", 32'(if2.inReady_o[2]), 32'h0);
      check("inactive in_ready D3", 32'(if3.inReady_o[2]), 32'h0);
      check("inactive out_valid D3", 32'(if3.outValid_o[2]), 32'h0);
      tick();
    end
    in_valid = '0; out_ready = '1;
    for (int c = 0; c < 4; c++) begin
      apply();
      tick();
    end
    lane_active = '1;

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      in_valid   = 4'($urandom);
      out_ready  = 4'($urandom) | 4'($urandom);
      br_resolve = ($urandom_range(0, 3) == 0);
      br_squash  = 1'($urandom);
      br_tag     = 3'($urandom);
      flush      = ($urandom_range(0, 63) == 0);
      for (int l = 0; l < NL; l++) begin
        in_mask[l] = BW'($urandom & $urandom & $urandom);
        in_data[l] = PW'($urandom);
      end
      apply();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
